// File: rtl/sdfa_pkg.sv
// Shared constants and state type for the sdfa weight-distribution slice.
package sdfa_pkg;

   localparam int unsigned SDFA_NUM_BLK         = 9;
   localparam int unsigned SDFA_WEIGHTS_PER_BLK = 114688;
   localparam int unsigned SDFA_W_WIDTH         = 8;

   typedef enum logic [2:0] {
      IDLE,
      SEEK,
      LOAD,
      WAIT_DONE,
      DONE
   } wd_state_t;

endpackage

// File: rtl/sdfa_blk_seek.sv
// Priority search: lowest set mask bit at or above the start index.
module sdfa_blk_seek #(
   parameter int unsigned NUM_BLK   = 9,
   parameter int unsigned BLK_IDX_W = $clog2(NUM_BLK)
) (
   input  logic [NUM_BLK-1:0]   mask,
   input  logic [BLK_IDX_W-1:0] start,
   output logic [BLK_IDX_W-1:0] idx,
   output logic                 found
);

   // Scan from the top down so the lowest qualifying index is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = NUM_BLK; i > 0; i--) begin
         if (mask[i-1] && ((i - 1) >= 32'(start))) begin
            idx   = BLK_IDX_W'(i - 1);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdfa_weight_distributor.sv
// Routes the serial weight stream to the selected sdfa blocks in ascending order,
// WEIGHTS_PER_BLK words each, and reports completion once all selected blocks are set.
module sdfa_weight_distributor
   import sdfa_pkg::*;
#(
   parameter int unsigned NUM_BLK         = SDFA_NUM_BLK,
   parameter int unsigned WEIGHTS_PER_BLK = SDFA_WEIGHTS_PER_BLK,
   parameter int unsigned W_WIDTH         = SDFA_W_WIDTH,
   parameter int unsigned BLK_IDX_W       = $clog2(NUM_BLK),
   parameter int unsigned CNT_W           = $clog2(WEIGHTS_PER_BLK)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         load_start,
   input  logic [NUM_BLK-1:0]           load_mask,
   input  logic                         w_valid,
   input  logic [W_WIDTH-1:0]           weight_in,
   output logic                         w_request,
   output logic [NUM_BLK-1:0]           blk_w_valid,
   output logic [NUM_BLK*W_WIDTH-1:0]   blk_weight,
   input  logic [NUM_BLK-1:0]           blk_w_request,
   input  logic [NUM_BLK-1:0]           blk_w_set_done,
   output logic [BLK_IDX_W-1:0]         cur_blk,
   output logic                         busy,
   output logic                         load_done,
   output logic                         all_done,
   output logic                         drop_err
);

   wd_state_t             state, state_nxt;
   logic [NUM_BLK-1:0]    mask;
   logic [CNT_W-1:0]      word_cnt;
   // Set once the highest-index block has been filled; cur_blk then stays put
   // instead of wrapping, so the following SEEK cannot restart a block.
   logic                  exhausted;
   logic [BLK_IDX_W-1:0]  seek_idx;
   logic                  seek_found;
   logic                  beat;
   logic                  last_beat;
   logic                  set_done_ok;

   sdfa_blk_seek #(
      .NUM_BLK   (NUM_BLK),
      .BLK_IDX_W (BLK_IDX_W)
   ) u_seek (
      .mask  (mask),
      .start (cur_blk),
      .idx   (seek_idx),
      .found (seek_found)
   );

   assign beat        = (state == LOAD) && w_valid;
   assign last_beat   = beat && (word_cnt == CNT_W'(WEIGHTS_PER_BLK - 1));
   assign set_done_ok = &(blk_w_set_done | ~mask);
   assign busy        = (state != IDLE) && (state != DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decision.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: if (load_start) state_nxt = SEEK;
         SEEK:       state_nxt = (seek_found && !exhausted) ? LOAD : WAIT_DONE;
         LOAD:       if (last_beat) state_nxt = SEEK;
         WAIT_DONE:  if (set_done_ok) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Pass bookkeeping: mask latch, block index, word counter and status flags.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mask      <= '0;
         word_cnt  <= '0;
         cur_blk   <= '0;
         exhausted <= 1'b0;
         load_done <= 1'b0;
         all_done  <= 1'b0;
         drop_err  <= 1'b0;
      end else begin
         load_done <= (state == WAIT_DONE) && set_done_ok;
         if (w_valid && (state != LOAD)) drop_err <= 1'b1;
         unique case (state)
            IDLE, DONE: begin
               if (load_start) begin
                  mask      <= load_mask;
                  cur_blk   <= '0;
                  word_cnt  <= '0;
                  exhausted <= 1'b0;
                  all_done  <= 1'b0;
               end
            end
            SEEK: begin
               if (seek_found && !exhausted) cur_blk <= seek_idx;
            end
            LOAD: begin
               if (last_beat) begin
                  word_cnt <= '0;
                  if (cur_blk == BLK_IDX_W'(NUM_BLK - 1)) exhausted <= 1'b1;
                  else                                     cur_blk   <= cur_blk + 1'b1;
               end else if (beat) begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (set_done_ok) all_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Steer valid, data and request for the block being loaded; everything else idles at 0.
   always_comb begin
      blk_w_valid = '0;
      blk_weight  = '0;
      w_request   = 1'b0;
      if (state == LOAD) begin
         for (int unsigned i = 0; i < NUM_BLK; i++) begin
            if (cur_blk == BLK_IDX_W'(i)) begin
               blk_w_valid[i]                    = w_valid;
               blk_weight[i*W_WIDTH +: W_WIDTH]  = weight_in;
               w_request                         = blk_w_request[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_sdfa_weight_distributor.sv
// Self-checking bench: reduced 3-block instance plus a 9-block instance for the full-width order.
module tb_sdfa_weight_distributor;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;

   // 3-block instance
   logic        load_start = 1'b0;
   logic [2:0]  load_mask = '0;
   logic        w_valid = 1'b0;
   logic [7:0]  weight_in = '0;
   logic        w_request;
   logic [2:0]  blk_w_valid;
   logic [23:0] blk_weight;
   logic [2:0]  blk_w_request = '0;
   logic [2:0]  blk_w_set_done = '0;
   logic [1:0]  cur_blk;
   logic        busy, load_done, all_done, drop_err;

   // 9-block instance
   logic        load_start9 = 1'b0;
   logic [8:0]  load_mask9 = '0;
   logic        w_valid9 = 1'b0;
   logic [7:0]  weight_in9 = '0;
   logic        w_request9;
   logic [8:0]  blk_w_valid9;
   logic [71:0] blk_weight9;
   logic [8:0]  blk_w_request9 = '0;
   logic [8:0]  blk_w_set_done9 = '0;
   logic [3:0]  cur_blk9;
   logic        busy9, load_done9, all_done9, drop_err9;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sdfa_weight_distributor #(
      .NUM_BLK         (3),
      .WEIGHTS_PER_BLK (4),
      .W_WIDTH         (8)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .load_start     (load_start),
      .load_mask      (load_mask),
      .w_valid        (w_valid),
      .weight_in      (weight_in),
      .w_request      (w_request),
      .blk_w_valid    (blk_w_valid),
      .blk_weight     (blk_weight),
      .blk_w_request  (blk_w_request),
      .blk_w_set_done (blk_w_set_done),
      .cur_blk        (cur_blk),
      .busy           (busy),
      .load_done      (load_done),
      .all_done       (all_done),
      .drop_err       (drop_err)
   );

   sdfa_weight_distributor #(
      .NUM_BLK         (9),
      .WEIGHTS_PER_BLK (16),
      .W_WIDTH         (8)
   ) dut9 (
      .clk            (clk),
      .rstn           (rstn),
      .load_start     (load_start9),
      .load_mask      (load_mask9),
      .w_valid        (w_valid9),
      .weight_in      (weight_in9),
      .w_request      (w_request9),
      .blk_w_valid    (blk_w_valid9),
      .blk_weight     (blk_weight9),
      .blk_w_request  (blk_w_request9),
      .blk_w_set_done (blk_w_set_done9),
      .cur_blk        (cur_blk9),
      .busy           (busy9),
      .load_done      (load_done9),
      .all_done       (all_done9),
      .drop_err       (drop_err9)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_w_request"}, w_request, 0);
      chk({tag, "_blk_w_valid"}, blk_w_valid, 0);
      chk({tag, "_blk_weight"}, blk_weight, 0);
      chk({tag, "_cur_blk"}, cur_blk, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_load_done"}, load_done, 0);
      chk({tag, "_all_done"}, all_done, 0);
      chk({tag, "_drop_err"}, drop_err, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      load_start = 1'b0; load_mask = '0; w_valid = 1'b0; weight_in = '0;
      blk_w_request = '0; blk_w_set_done = '0;
      @(posedge clk); #1;
      check_all_zero("reset");
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // One load pass on the 3-block instance against a block-list model:
   // the selected blocks in ascending order, each taking 4 words, a one-cycle
   // search before each block and one after the last, then the set-done wait.
   task automatic run_pass(input logic [2:0] m, input bit rnd, output int done_cyc);
      int   sel[$];
      int   j, c, cyc, delay, beats, b;
      bit   seeking, waiting, loading, done, v;
      logic [2:0]  req, exp_v;
      logic [7:0]  wd;
      logic [23:0] exp_w;
      sel = {};
      for (int i = 0; i < 3; i++) if (m[i]) sel.push_back(i);
      @(negedge clk);
      load_start = 1'b1; load_mask = m; blk_w_set_done = '0; w_valid = 1'b0; blk_w_request = '1;
      @(posedge clk); #1;
      load_start = 1'b0; load_mask = 3'($urandom);
      chk("accept_busy", busy, 1);
      chk("accept_all_done_clr", all_done, 0);
      j = 0; c = 0; beats = 0; seeking = 1; waiting = 0; done = 0; cyc = 1; done_cyc = -1;
      delay = (rnd && sel.size() > 0) ? $urandom_range(0, 4) : 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         loading = !seeking && !waiting;
         b = 0;
         if (loading) b = sel[j];
         req = rnd ? 3'($urandom) : 3'b111;
         v   = loading && req[b] && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         wd  = rnd ? 8'($urandom) : 8'(beats + 1);
         blk_w_request = req; w_valid = v; weight_in = wd;
         load_start = rnd && ($urandom_range(0, 5) == 0);
         load_mask  = 3'($urandom);
         if (waiting) begin
            if (delay == 0) blk_w_set_done = m | (3'($urandom) & ~m);
            else blk_w_set_done = (3'($urandom) & m & ~(3'b001 << sel[0])) | (~m & 3'($urandom));
         end
         #1;
         exp_v = v ? (3'b001 << b) : 3'b000;
         exp_w = loading ? (24'(wd) << (8 * b)) : 24'h0;
         chk("blk_w_valid", blk_w_valid, exp_v);
         chk("blk_weight", blk_weight, exp_w);
         chk("w_request", w_request, loading ? req[b] : 1'b0);
         chk("busy_in_pass", busy, 1);
         chk("load_done_early", load_done, 0);
         chk("all_done_in_pass", all_done, 0);
         if (loading) chk("cur_blk", cur_blk, b);
         @(posedge clk);
         if (seeking) begin
            seeking = 0;
            if (j >= sel.size()) waiting = 1;
         end else if (waiting) begin
            if (delay == 0) done = 1;
            else delay--;
         end else if (v) begin
            beats++; c++;
            if (c == 4) begin c = 0; j++; seeking = 1; end
         end
         cyc++;
      end
      #1;
      w_valid = 1'b0; load_start = 1'b0;
      if (!done) begin
         chk("pass_timeout", 0, 1);
      end else begin
         done_cyc = cyc;
         chk("load_done", load_done, 1);
         chk("all_done", all_done, 1);
         chk("busy_done", busy, 0);
         chk("drop_err_clean", drop_err, 0);
         chk("beats_total", beats, 4 * sel.size());
         @(posedge clk); #1;
         chk("load_done_pulse", load_done, 0);
         chk("all_done_hold", all_done, 1);
      end
   endtask

   typedef struct {
      logic [2:0] mask;
      int         done_cyc;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int dc, beats, k, last9;
      bit got;

      tbl[0] = '{3'b111, 18};
      tbl[1] = '{3'b101, 13};
      tbl[2] = '{3'b000, 3};
      tbl[3] = '{3'b010, 8};
      tbl[4] = '{3'b110, 13};
      tbl[5] = '{3'b100, 8};

      do_reset();

      // Directed passes with back-to-back words 01, 02, ... and immediate set-done.
      for (int i = 0; i < 6; i++) begin
         run_pass(tbl[i].mask, 1'b0, dc);
         chk("done_cycle", dc, tbl[i].done_cyc);
      end

      // Reset in the middle of a pass, with w_valid held high across it.
      @(negedge clk);
      load_start = 1'b1; load_mask = 3'b111; blk_w_request = '1; blk_w_set_done = '0;
      @(posedge clk); #1;
      load_start = 1'b0;
      beats = 0;
      for (int t = 0; t < 20 && beats < 6; t++) begin
         @(negedge clk);
         w_valid = w_request; weight_in = 8'(8'hA0 + beats);
         @(posedge clk); #1;
         if (w_valid) beats++;
      end
      chk("mid_beats", beats, 6);
      chk("mid_cur_blk", cur_blk, 1);
      @(negedge clk);
      rstn = 1'b0; w_valid = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midreset");
      @(negedge clk);
      rstn = 1'b1; w_valid = 1'b0;
      run_pass(3'b111, 1'b0, dc);
      chk("restart_done_cycle", dc, 18);

      // Words outside LOAD: in IDLE, then in the SEEK cycle.
      @(negedge clk);
      w_valid = 1'b1; weight_in = 8'h55;
      #1;
      chk("idle_no_valid", blk_w_valid, 0);
      chk("idle_no_weight", blk_weight, 0);
      @(posedge clk); #1;
      chk("idle_drop_err", drop_err, 1);
      @(negedge clk);
      w_valid = 1'b0;
      @(posedge clk); #1;
      chk("drop_err_sticky", drop_err, 1);
      do_reset();
      @(negedge clk);
      load_start = 1'b1; load_mask = 3'b011; blk_w_request = '1;
      @(posedge clk); #1;
      load_start = 1'b0;
      @(negedge clk);
      w_valid = 1'b1; weight_in = 8'h77;
      #1;
      chk("seek_no_valid", blk_w_valid, 0);
      chk("seek_no_request", w_request, 0);
      @(posedge clk); #1;
      chk("seek_drop_err", drop_err, 1);
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         w_valid = 1'b1; weight_in = 8'(t);
         #1;
         chk("after_drop_route", blk_w_valid, 3'b001);
         @(posedge clk);
      end
      #1;
      w_valid = 1'b0;
      chk("after_drop_cur_blk", cur_blk, 1);
      chk("drop_err_held", drop_err, 1);
      do_reset();

      // Randomised passes: random masks, request gaps, source gaps, late set-done
      // and load_start pulses while busy.
      for (int i = 0; i < 25; i++) run_pass(3'($urandom), 1'b1, dc);

      // Nine-block instance: every block selected, source follows w_request.
      @(negedge clk);
      load_start9 = 1'b1; load_mask9 = '1; blk_w_set_done9 = '0;
      @(posedge clk); #1;
      load_start9 = 1'b0;
      k = 0; last9 = -1;
      for (int t = 0; t < 1000 && k < 144; t++) begin
         @(negedge clk);
         blk_w_request9 = 9'($urandom);
         #1;
         w_valid9 = w_request9; weight_in9 = 8'(k);
         #1;
         chk("w_request9_track", w_request9 & ~blk_w_request9[k / 16], 0);
         chk("blk_w_valid9", blk_w_valid9, w_valid9 ? (9'b1 << (k / 16)) : 9'b0);
         if (w_valid9) begin
            chk("blk_weight9", blk_weight9, 72'(k[7:0]) << (8 * (k / 16)));
            chk("cur_blk9", cur_blk9, k / 16);
         end
         @(posedge clk); #1;
         if (w_valid9) begin last9 = k / 16; k++; end
      end
      w_valid9 = 1'b0;
      chk("beats9", k, 144);
      chk("last_block9", last9, 8);
      @(negedge clk);
      blk_w_set_done9 = '1;
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(posedge clk); #1;
         if (all_done9) got = 1;
      end
      chk("all_done9", all_done9, 1);
      chk("busy9_done", busy9, 0);
      chk("drop_err9", drop_err9, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
